ball_axis_counter: RTL and testbench
====================================

Name: ball_axis_counter

Overview:
- Bidirectional bounded position counter for one axis of the ball (X or Y) in the Pong datapath.
- Steps one unit per EN tick between MIN and MAX.
- Reverses direction on wall contact or on a paddle HIT.
- Its Q output feeds the collision/score comparators and the display row/column decode. It is the flip-flop-level state stage directly downstream of the game-tick divider.

Parameters:
- WIDTH, 4, bit width of position Q.
- MIN, 0, lowest legal position (wall); 0 <= MIN.
- MAX, 15, highest legal position (wall); MIN < MAX <= 2^WIDTH-1.
- CENTER, 8, reset/serve position; MIN <= CENTER <= MAX.

Ports:
- CK, input, 1, clock; all state updates on rising edge.
- RESET_N, input, 1, asynchronous active-low reset.
- EN, input, 1, step tick (one-cycle pulse from tick divider); step occurs only on edges where EN=1.
- START, input, 1, serve: leave IDLE and begin moving.
- START_DIR, input, 1, initial direction on START (1=up/increment, 0=down).
- HIT, input, 1, paddle collision: reverse direction on this step.
- LOAD, input, 1, synchronous load of LOAD_VAL; forces IDLE.
- LOAD_VAL, input, WIDTH, position to load.
- Q, output, WIDTH, current position (registered).
- DIR, output, 1, current direction, 1=up (registered).
- MOVING, output, 1, 1 when in MOVE_UP/MOVE_DOWN.
- AT_MIN, output, 1, Q==MIN (registered decode).
- AT_MAX, output, 1, Q==MAX (registered decode).
- BOUNCE, output, 1, one-cycle pulse after a wall reversal.

Behaviour:
- Reset (RESET_N=0, asynchronous, immediate):
  - Q=CENTER, DIR=1, state IDLE, MOVING=0, BOUNCE=0.
  - AT_MIN=(CENTER==MIN), AT_MAX=(CENTER==MAX).
  - Reset mid-motion discards all state.
- States:
  - IDLE: Q holds. EN and HIT are ignored.
  - MOVE_UP (DIR=1) and MOVE_DOWN (DIR=0).
- Priority per rising CK edge: LOAD > START (IDLE only) > EN step.
- LOAD:
  - Q = clamp(LOAD_VAL, MIN, MAX); state IDLE; DIR unchanged; BOUNCE=0.
  - Out-of-range values are clamped, never wrapped.
- START in IDLE: state = START_DIR ? MOVE_UP : MOVE_DOWN; DIR=START_DIR; Q unchanged this edge (first step on a later EN). START outside IDLE is ignored.
- EN step while moving:
  - wall = (DIR=1 and Q==MAX) or (DIR=0 and Q==MIN).
  - rev = wall OR HIT (HIT sampled only when EN=1).
  - A simultaneous wall and HIT is a single reversal, not a double flip.
  - rev=0: Q = Q+1 (DIR=1) or Q-1 (DIR=0); direction kept.
  - rev=1: DIR toggles; Q steps one unit in the new direction (MAX -> MAX-1, MIN -> MIN+1).
  - HIT away from a wall behaves the same: e.g. Q=5 up + HIT -> Q=4, DIR=0.
- No-wrap guarantee: Q never leaves [MIN,MAX]; no arithmetic wrap at 0 or 2^WIDTH-1.
- BOUNCE:
  - High for exactly one cycle after an edge where wall=1 caused reversal (including wall+HIT).
  - A HIT-only reversal gives BOUNCE=0.
  - Deasserted on the next edge regardless of EN.
- Latency: Q/DIR/AT_*/BOUNCE all update on the same edge as the causing input; no combinational input-to-output paths.
- EN=0 edges: Q/DIR/state hold; BOUNCE clears.

Test Plan:
1. Reset with LOAD/START/EN idle -> Q=8, DIR=1, MOVING=0, AT_MIN=0, AT_MAX=0, BOUNCE=0. Assert RESET_N mid-motion at Q=12 -> Q=8 immediately, before any CK edge.
2. START, START_DIR=1, then 7 EN pulses -> Q=15, AT_MAX=1. Next EN -> Q=14, DIR=0, BOUNCE high exactly one cycle.
3. LOAD_VAL=1, START_DIR=0, START, EN -> Q=0, AT_MIN=1. Next EN -> Q=1, DIR=1, BOUNCE=1.
4. Moving up at Q=5, EN+HIT -> Q=4, DIR=0, BOUNCE=0. At Q=15 going up, EN+HIT -> Q=14, DIR=0 (single reversal), BOUNCE=1.
5. EN held low for 10 cycles while moving -> Q unchanged. In IDLE, EN+HIT pulses -> Q, DIR unchanged.
6. While moving at Q=10, LOAD and EN together with LOAD_VAL=3 -> Q=3, MOVING=0. Then LOAD_VAL=MAX+1 with MIN=2, MAX=12 parameterisation -> Q=12 (clamped). START in MOVE_* state -> ignored.

Source files
------------

// File: rtl/ball_axis_counter.sv
// One axis of the ball position: bounded up/down counter stepped by the game tick,
// reversing on wall contact or paddle hit, with clamped load and serve control.
//
// state     | meaning
// ----------+------------------------------------------------
// S_IDLE    | ball parked, Q holds, EN/HIT ignored
// S_UP      | moving toward MAX, one unit per EN tick
// S_DOWN    | moving toward MIN, one unit per EN tick
module ball_axis_counter #(
  parameter int WIDTH  = 4,
  parameter int MIN    = 0,
  parameter int MAX    = 15,
  parameter int CENTER = 8
) (
  input  logic             CK,
  input  logic             RESET_N,
  input  logic             EN,
  input  logic             START,
  input  logic             START_DIR,
  input  logic             HIT,
  input  logic             LOAD,
  input  logic [WIDTH-1:0] LOAD_VAL,
  output logic [WIDTH-1:0] Q,
  output logic             DIR,
  output logic             MOVING,
  output logic             AT_MIN,
  output logic             AT_MAX,
  output logic             BOUNCE
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_UP   = 2'd1;
  localparam logic [1:0] S_DOWN = 2'd2;

  localparam logic [WIDTH-1:0] MIN_Q    = WIDTH'(MIN);
  localparam logic [WIDTH-1:0] MAX_Q    = WIDTH'(MAX);
  localparam logic [WIDTH-1:0] CENTER_Q = WIDTH'(CENTER);
  localparam logic [WIDTH-1:0] ONE_Q    = WIDTH'(1);

  logic [1:0]       state_q, state_d;
  logic [WIDTH-1:0] q_q, q_d;
  logic             dir_q, dir_d;
  logic             bounce_q, bounce_d;
  logic             at_min_q, at_max_q;
  logic [WIDTH-1:0] load_clamped;
  logic             moving;
  logic             wall;
  logic             rev;
  int               lv_int;

  assign moving = (state_q != S_IDLE);

  // Signed integer compare keeps the clamp free of unsigned/limited-range corner cases.
  always_comb begin
    lv_int = int'(LOAD_VAL);
    if (lv_int < MIN)      load_clamped = MIN_Q;
    else if (lv_int > MAX) load_clamped = MAX_Q;
    else                   load_clamped = LOAD_VAL;
  end

  always_comb begin
    state_d  = state_q;
    q_d      = q_q;
    dir_d    = dir_q;
    bounce_d = 1'b0;
    rev      = 1'b0;
    wall     = moving && ((dir_q && (q_q == MAX_Q)) || (!dir_q && (q_q == MIN_Q)));
    if (LOAD) begin
      state_d = S_IDLE;
      q_d     = load_clamped;
    end else if (!moving) begin
      if (START) begin
        state_d = START_DIR ? S_UP : S_DOWN;
        dir_d   = START_DIR;
      end
    end else if (EN) begin
      rev      = wall | HIT;
      dir_d    = dir_q ^ rev;
      bounce_d = wall;
      // A HIT that points into the wall we are sitting on saturates rather than wraps.
      if (dir_d) q_d = (q_q == MAX_Q) ? q_q : q_q + ONE_Q;
      else       q_d = (q_q == MIN_Q) ? q_q : q_q - ONE_Q;
      state_d = dir_d ? S_UP : S_DOWN;
    end
  end

  always_ff @(posedge CK or negedge RESET_N) begin
    if (!RESET_N) begin
      state_q  <= S_IDLE;
      q_q      <= CENTER_Q;
      dir_q    <= 1'b1;
      bounce_q <= 1'b0;
      at_min_q <= (CENTER == MIN);
      at_max_q <= (CENTER == MAX);
    end else begin
      state_q  <= state_d;
      q_q      <= q_d;
      dir_q    <= dir_d;
      bounce_q <= bounce_d;
      at_min_q <= (q_d == MIN_Q);
      at_max_q <= (q_d == MAX_Q);
    end
  end

  assign Q      = q_q;
  assign DIR    = dir_q;
  assign MOVING = moving;
  assign AT_MIN = at_min_q;
  assign AT_MAX = at_max_q;
  assign BOUNCE = bounce_q;

endmodule

// File: tb/tb_ball_axis_counter.sv
// Bench for ball_axis_counter: per-cycle reference model feeding a scoreboard queue,
// plus directed checks, and a second instance with a narrowed MIN/MAX for clamping.
module tb_ball_axis_counter;

  logic       CK = 1'b0;
  logic       RESET_N = 1'b0;
  logic       EN = 1'b0, START = 1'b0, START_DIR = 1'b0, HIT = 1'b0, LOAD = 1'b0;
  logic [3:0] LOAD_VAL = 4'd0;
  logic [3:0] Q, Q2;
  logic       DIR, MOVING, AT_MIN, AT_MAX, BOUNCE;
  logic       DIR2, MOVING2, AT_MIN2, AT_MAX2, BOUNCE2;

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct {
    int q;
    int dir;
    int mov;
    int amin;
    int amax;
    int bnc;
  } exp_t;
  exp_t sb[$];

  int m_q = 8, m_dir = 1, m_mov = 0, m_bnc = 0;

  always #5 CK = ~CK;

  ball_axis_counter #(.WIDTH(4), .MIN(0), .MAX(15), .CENTER(8)) dut (
    .CK(CK), .RESET_N(RESET_N), .EN(EN), .START(START), .START_DIR(START_DIR),
    .HIT(HIT), .LOAD(LOAD), .LOAD_VAL(LOAD_VAL), .Q(Q), .DIR(DIR), .MOVING(MOVING),
    .AT_MIN(AT_MIN), .AT_MAX(AT_MAX), .BOUNCE(BOUNCE)
  );

  ball_axis_counter #(.WIDTH(4), .MIN(2), .MAX(12), .CENTER(8)) dut2 (
    .CK(CK), .RESET_N(RESET_N), .EN(EN), .START(START), .START_DIR(START_DIR),
    .HIT(HIT), .LOAD(LOAD), .LOAD_VAL(LOAD_VAL), .Q(Q2), .DIR(DIR2), .MOVING(MOVING2),
    .AT_MIN(AT_MIN2), .AT_MAX(AT_MAX2), .BOUNCE(BOUNCE2)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  function automatic void model_reset();
    m_q = 8; m_dir = 1; m_mov = 0; m_bnc = 0;
  endfunction

  // Reference behaviour for the default 0..15 instance.
  function automatic void model_step(input bit ld, input int lv, input bit st, input bit sd,
                                     input bit en, input bit hit);
    bit wall;
    m_bnc = 0;
    if (ld) begin
      m_q   = (lv > 15) ? 15 : lv;
      m_mov = 0;
    end else if (m_mov == 0) begin
      if (st) begin
        m_mov = 1;
        m_dir = sd;
      end
    end else if (en) begin
      wall = (m_dir == 1 && m_q == 15) || (m_dir == 0 && m_q == 0);
      m_bnc = wall;
      if (wall || hit) m_dir = 1 - m_dir;
      if (m_dir == 1) m_q = (m_q == 15) ? 15 : m_q + 1;
      else            m_q = (m_q == 0) ? 0 : m_q - 1;
    end
  endfunction

  task automatic cyc(input string tag, input bit ld, input int lv, input bit st, input bit sd,
                     input bit en, input bit hit);
    exp_t e;
    exp_t g;
    @(negedge CK);
    LOAD = ld; LOAD_VAL = lv[3:0]; START = st; START_DIR = sd; EN = en; HIT = hit;
    model_step(ld, lv, st, sd, en, hit);
    e.q = m_q; e.dir = m_dir; e.mov = m_mov;
    e.amin = (m_q == 0); e.amax = (m_q == 15); e.bnc = m_bnc;
    sb.push_back(e);
    @(posedge CK);
    #1;
    if (sb.size() == 0) begin
      chk({tag, "_sb_empty"}, 0, 1);
    end else begin
      g = sb.pop_front();
      chk({tag, "_q"},      32'(Q),      32'(g.q));
      chk({tag, "_dir"},    32'(DIR),    32'(g.dir));
      chk({tag, "_moving"}, 32'(MOVING), 32'(g.mov));
      chk({tag, "_at_min"}, 32'(AT_MIN), 32'(g.amin));
      chk({tag, "_at_max"}, 32'(AT_MAX), 32'(g.amax));
      chk({tag, "_bounce"}, 32'(BOUNCE), 32'(g.bnc));
    end
    LOAD = 0; START = 0; EN = 0; HIT = 0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // 1: reset values and asynchronous reset mid-motion
    #12;
    chk("rst_q", 32'(Q), 8);
    chk("rst_dir", 32'(DIR), 1);
    chk("rst_moving", 32'(MOVING), 0);
    chk("rst_at_min", 32'(AT_MIN), 0);
    chk("rst_at_max", 32'(AT_MAX), 0);
    chk("rst_bounce", 32'(BOUNCE), 0);
    chk("rst2_q", 32'(Q2), 8);
    @(negedge CK);
    RESET_N = 1'b1;
    cyc("serve_up", 0, 0, 1, 1, 0, 0);
    for (int i = 0; i < 4; i++) cyc("run_to12", 0, 0, 0, 0, 1, 0);
    chk("mid_q12", 32'(Q), 12);
    #2;
    RESET_N = 1'b0;
    #1;
    chk("async_rst_q", 32'(Q), 8);
    chk("async_rst_moving", 32'(MOVING), 0);
    chk("async_rst_dir", 32'(DIR), 1);
    model_reset();
    @(negedge CK);
    RESET_N = 1'b1;

    // 2: run up into MAX, wall bounce
    cyc("serve_up2", 0, 0, 1, 1, 0, 0);
    for (int i = 0; i < 7; i++) cyc("up_to_max", 0, 0, 0, 0, 1, 0);
    chk("max_q", 32'(Q), 15);
    chk("max_at_max", 32'(AT_MAX), 1);
    cyc("wall_max", 0, 0, 0, 0, 1, 0);
    chk("wall_max_q", 32'(Q), 14);
    chk("wall_max_bounce", 32'(BOUNCE), 1);
    cyc("bounce_clear", 0, 0, 0, 0, 0, 0);
    chk("bounce_one_cycle", 32'(BOUNCE), 0);

    // 3: load 1, serve down into MIN, wall bounce
    cyc("load1", 1, 1, 0, 0, 0, 0);
    cyc("serve_dn", 0, 0, 1, 0, 0, 0);
    cyc("to_min", 0, 0, 0, 0, 1, 0);
    chk("min_q", 32'(Q), 0);
    chk("min_at_min", 32'(AT_MIN), 1);
    cyc("wall_min", 0, 0, 0, 0, 1, 0);
    chk("wall_min_q", 32'(Q), 1);
    chk("wall_min_dir", 32'(DIR), 1);
    chk("wall_min_bounce", 32'(BOUNCE), 1);

    // 4: HIT away from wall, then HIT together with wall
    for (int i = 0; i < 4; i++) cyc("up_to5", 0, 0, 0, 0, 1, 0);
    cyc("hit_mid", 0, 0, 0, 0, 1, 1);
    chk("hit_mid_q", 32'(Q), 4);
    chk("hit_mid_dir", 32'(DIR), 0);
    chk("hit_mid_bounce", 32'(BOUNCE), 0);
    cyc("load14", 1, 14, 0, 0, 0, 0);
    cyc("serve_up3", 0, 0, 1, 1, 0, 0);
    cyc("to15", 0, 0, 0, 0, 1, 0);
    cyc("hit_wall", 0, 0, 0, 0, 1, 1);
    chk("hit_wall_q", 32'(Q), 14);
    chk("hit_wall_dir", 32'(DIR), 0);
    chk("hit_wall_bounce", 32'(BOUNCE), 1);

    // 5: EN low holds; IDLE ignores EN/HIT
    for (int i = 0; i < 10; i++) cyc("en_low", 0, 0, 0, 0, 0, 0);
    chk("en_low_q", 32'(Q), 14);
    cyc("load6", 1, 6, 0, 0, 0, 0);
    for (int i = 0; i < 3; i++) cyc("idle_en_hit", 0, 0, 0, 0, 1, 1);
    chk("idle_q", 32'(Q), 6);
    chk("idle_dir", 32'(DIR), 0);

    // 6: LOAD beats EN; START while moving ignored; clamping on narrowed instance
    cyc("serve_up4", 0, 0, 1, 1, 0, 0);
    for (int i = 0; i < 4; i++) cyc("up_to10", 0, 0, 0, 0, 1, 0);
    cyc("load_en", 1, 3, 0, 0, 1, 0);
    chk("load_en_q", 32'(Q), 3);
    chk("load_en_moving", 32'(MOVING), 0);
    cyc("serve_up5", 0, 0, 1, 1, 0, 0);
    cyc("start_ignored", 0, 0, 1, 0, 0, 0);
    chk("start_ignored_dir", 32'(DIR), 1);
    cyc("load13", 1, 13, 0, 0, 0, 0);
    chk("clamp_hi_q", 32'(Q2), 12);
    chk("clamp_hi_at_max", 32'(AT_MAX2), 1);
    cyc("load0", 1, 0, 0, 0, 0, 0);
    chk("clamp_lo_q", 32'(Q2), 2);
    chk("clamp_lo_at_min", 32'(AT_MIN2), 1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
